// File: rtl/br_pkg.sv
// Shared types and defaults for the branch resolve controller.
// Optional statistics counters are enabled by defining BR_STATS_EN.
package br_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FLAGS = 2'd1,
    FLUSH      = 2'd2
  } br_state_t;

  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/branch_ctrl_if.sv
// Resolve-stage bundle between the pipeline and the branch controller.
// master = pipeline side, slave = branch_ctrl.
interface branch_ctrl_if
  import br_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             br_valid;
  logic             UncondBr;
  logic             flagEn;
  logic             BCondCheck;
  logic             zero;
  logic             flag_busy;
  logic             BrTaken;
  logic             flush;
  logic             stall;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] nottaken_cnt;

  modport master (
    output br_valid,
    output UncondBr,
    output flagEn,
    output BCondCheck,
    output zero,
    output flag_busy,
    input  BrTaken,
    input  flush,
    input  stall,
    input  taken_cnt,
    input  nottaken_cnt
  );

  modport slave (
    input  br_valid,
    input  UncondBr,
    input  flagEn,
    input  BCondCheck,
    input  zero,
    input  flag_busy,
    output BrTaken,
    output flush,
    output stall,
    output taken_cnt,
    output nottaken_cnt
  );

endinterface

// File: rtl/br_outcome.sv
// Branch outcome decode: B/BL always, CBZ on zero, B.cond on flags.
// Unknown inputs resolve to not-taken in simulation.
module br_outcome (
  input  logic UncondBr,
  input  logic flagEn,
  input  logic BCondCheck,
  input  logic zero,
  output logic taken
);

  logic raw;

  assign raw   = UncondBr | (flagEn ? zero : BCondCheck);
  assign taken = (raw === 1'b1);

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolve FSM: waits for flags, pulses BrTaken, flushes IF/ID.
// Define BR_STATS_EN to build the taken/not-taken statistics counters.
module branch_ctrl
  import br_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  branch_ctrl_if.slave bus
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  br_state_t  state;
  logic [2:0] fcnt;
  logic       br_q;
  logic       flush_q;
  logic       taken;
  logic       cond_wait;
  logic       in_idle;
  logic       in_wait;
  logic       resolve;

  br_outcome u_outcome (
    .UncondBr  (bus.UncondBr),
    .flagEn    (bus.flagEn),
    .BCondCheck(bus.BCondCheck),
    .zero      (bus.zero),
    .taken     (taken)
  );

  assign in_idle = (state == IDLE);
  assign in_wait = (state == WAIT_FLAGS);

  // Only B.cond depends on flags still being produced.
  assign cond_wait = bus.br_valid & ~bus.UncondBr
                   & ~bus.flagEn & bus.flag_busy;

  assign resolve = (in_idle & bus.br_valid & ~cond_wait)
                 | (in_wait & ~bus.flag_busy);

  assign bus.stall = reset & ((in_idle & cond_wait)
                   | (in_wait & bus.flag_busy));

  assign bus.BrTaken = br_q;
  assign bus.flush   = flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      fcnt    <= '0;
      br_q    <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      br_q <= 1'b0;
      case (state)
        IDLE, WAIT_FLAGS: begin
          if (resolve && taken) begin
            state   <= FLUSH;
            fcnt    <= FLUSH_LAST;
            br_q    <= 1'b1;
            flush_q <= 1'b1;
          end else if (resolve) begin
            state <= IDLE;
          end else if (in_idle && cond_wait) begin
            state <= WAIT_FLAGS;
          end
        end
        FLUSH: begin
          if (fcnt == 3'd0) begin
            state   <= IDLE;
            flush_q <= 1'b0;
          end else begin
            fcnt <= fcnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BR_STATS_EN
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] tk_q;
  logic [CNT_W-1:0] ntk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tk_q  <= '0;
      ntk_q <= '0;
    end else if (resolve) begin
      if (taken && tk_q != CMAX)
        tk_q <= tk_q + 1'b1;
      if (!taken && ntk_q != CMAX)
        ntk_q <= ntk_q + 1'b1;
    end
  end

  assign bus.taken_cnt    = tk_q;
  assign bus.nottaken_cnt = ntk_q;
`else
  assign bus.taken_cnt    = '0;
  assign bus.nottaken_cnt = '0;
`endif

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: cycles of flush after a taken branch (legal range 1..7).
REQ-002 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port br_valid, input, 1: a branch instruction is in the resolve stage this cycle.
REQ-006 SHALL have port UncondBr, input, 1: the branch is unconditional (B/BL).
REQ-007 SHALL have port flagEn, input, 1: the branch is compare-and-branch (CBZ); outcome is given by zero.
REQ-008 SHALL have port BCondCheck, input, 1: condition result for B.cond, evaluated against the current flags.
REQ-009 SHALL have port zero, input, 1: ALU zero result for CBZ.
REQ-010 SHALL have port flag_busy, input, 1: an older in-flight instruction has not yet written the flags.
REQ-011 SHALL have port BrTaken, output, 1: registered 1-cycle pulse selecting the branch target PC.
REQ-012 SHALL have port flush, output, 1: registered; squashes the IF/ID instructions.
REQ-013 SHALL have port stall, output, 1: combinational; freezes PC and IF/ID while a B.cond waits for flags.
REQ-014 SHALL have ports taken_cnt and nottaken_cnt, output, CNT_W each: branch statistics (see Configuration).

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT_FLAGS and FLUSH.
REQ-016 The outcome SHALL be taken = UncondBr | (flagEn ? zero : BCondCheck); in simulation, any X/Z on these inputs SHALL resolve to not-taken.
REQ-017 In IDLE with br_valid=1, UncondBr=0, flagEn=0 and flag_busy=1, the block SHALL assert stall in the same cycle and go to WAIT_FLAGS.
REQ-018 In IDLE with br_valid=1 and no wait condition, the branch SHALL resolve in that cycle (the "resolve cycle").
REQ-019 UncondBr=1 or flagEn=1 SHALL never wait on flag_busy.
REQ-020 In WAIT_FLAGS, stall SHALL equal flag_busy; the first cycle with flag_busy=0 SHALL be the resolve cycle, using that cycle's BCondCheck.
REQ-021 A taken resolve SHALL produce BrTaken=1 for exactly the one cycle after the resolve cycle.
REQ-022 A taken resolve SHALL also produce flush=1 for FLUSH_CYCLES consecutive cycles starting that same cycle, with the FSM in FLUSH.
REQ-023 A not-taken resolve SHALL return to or stay in IDLE with no BrTaken or flush.
REQ-024 In FLUSH, br_valid SHALL be ignored (the instruction is squashed); the down-counter reaching 0 SHALL return the FSM to IDLE.
REQ-025 A branch presented in the first cycle after FLUSH ends SHALL be accepted normally (back-to-back branches).
REQ-026 stall SHALL be 0 outside the conditions in REQ-017 and REQ-020.
REQ-027 stall and flush SHALL never be 1 in the same cycle.

Reset
REQ-028 Asserting reset (low) at any time SHALL immediately force state=IDLE, BrTaken=0, flush=0, stall=0, the flush counter to 0 and both stats counters to 0.
REQ-029 Reset asserted mid-WAIT_FLAGS or mid-FLUSH SHALL abandon the pending operation; no BrTaken pulse occurs after reset release.

Configuration
REQ-030 Macro BR_STATS_EN defined: taken_cnt and nottaken_cnt SHALL increment by 1 on each taken or not-taken resolve, saturating at 2^CNT_W-1.
REQ-031 BR_STATS_EN undefined: no counter flops SHALL exist, and both outputs SHALL be tied to 0.

Structure
REQ-032 Shared package br_pkg SHALL hold the state enum typedef br_state_t (IDLE, WAIT_FLAGS, FLUSH) and the constant default FLUSH_CYCLES.
REQ-033 The outcome decode of REQ-016 SHALL be the single combinational sub-module br_outcome; the FSM, counters and stats SHALL stay in branch_ctrl.

Verification
REQ-034 Scenario: reset low, then high; br_valid=1, UncondBr=1 -> next cycle BrTaken=1; flush=1 for 2 cycles; stall stays 0.
REQ-035 Scenario: br_valid=1, flagEn=1, zero=0 -> no BrTaken or flush; with BR_STATS_EN, nottaken_cnt=1.
REQ-036 Scenario: B.cond with flag_busy=1 for 3 cycles, then BCondCheck=1 -> stall=1 for exactly 3 cycles; BrTaken pulses the cycle after flag_busy falls.
REQ-037 Scenario: br_valid held 1 during FLUSH, then a CBZ with zero=1 the cycle FLUSH ends -> second BrTaken accepted; the squashed cycles add no count.
REQ-038 Scenario: reset pulsed low in the 2nd WAIT_FLAGS cycle -> stall falls immediately; no BrTaken afterward; counters read 0.
REQ-039 Scenario: with BR_STATS_EN and CNT_W=2, five taken branches -> taken_cnt saturates at 3.
